// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load/store unit: funct3 encodings,
// LSU FSM state encoding and the access alignment rule.
package riscv_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Size comes from funct3[1:0]; the reserved size code is treated as a word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: req/gnt request phase, rvalid/rdata read-return phase.
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select and extension
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one decoded load or store into a single
// req/gnt/rvalid bus transaction, stalling the pipeline until it completes.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            bus_err,
  load_store_unit_if.master bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_t      state;
  logic [7:0]      tmo_cnt;
  logic [2:0]      funct3_q;
  logic [1:0]      offset_q;
  logic            request;
  logic            unaligned;
  logic            is_idle;
  logic [3:0]      wstrb_n;
  logic [XLEN-1:0] wdata_n;
  logic [XLEN-1:0] rdata_ext;

  assign request   = mem_read | mem_write;
  assign unaligned = is_misaligned(funct3, addr[1:0]);
  assign is_idle   = (state == IDLE);

  // Gated by rst so every output reads 0 while reset is held, even with a request pending.
  assign stall      = !rst && ((is_idle && request && !unaligned) || state == REQ || state == RESP);
  assign misaligned = !rst && is_idle && request && unaligned;

  // Store lane placement: replicate data across the word, enable only the addressed bytes
  always_comb begin
    wstrb_n = 4'b1111;
    wdata_n = store_data;
    case (funct3)
      F3_SB: begin
        wstrb_n = 4'b0001 << addr[1:0];
        wdata_n = {4{store_data[7:0]}};
      end
      F3_SH: begin
        wstrb_n = 4'b0011 << {addr[1], 1'b0};
        wdata_n = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (bus.rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (rdata_ext)
  );

  // Access FSM with timeout counter and registered bus/handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      funct3_q   <= '0;
      offset_q   <= '0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
      load_data  <= '0;
      bus.req    <= 1'b0;
      bus.we     <= 1'b0;
      bus.addr   <= '0;
      bus.wdata  <= '0;
      bus.wstrb  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      done    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (request && !unaligned) begin
            state     <= REQ;
            tmo_cnt   <= '0;
            funct3_q  <= funct3;
            offset_q  <= addr[1:0];
            bus.req   <= 1'b1;
            bus.we    <= mem_write;  // write wins when both requests are high
            bus.addr  <= {addr[XLEN-1:2], 2'b00};
            bus.wdata <= wdata_n;
            bus.wstrb <= wstrb_n;
          end
        end
        REQ: begin
          if (bus.gnt) begin
            bus.req <= 1'b0;
            tmo_cnt <= '0;
            if (bus.we) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RESP;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            bus.req   <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            load_data <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          if (bus.rvalid) begin
            load_data <= rdata_ext;
            state     <= DONE;
            done      <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            bus_err   <= 1'b1;
            load_data <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
